// File: rtl/shift4_ctrl_pkg.sv
// Shared types and widths for the shift4_ctrl sequencer.
// Optional stall support is enabled by defining SHIFT4_CTRL_PAUSE_EN.
package shift4_ctrl_pkg;

  localparam int SR_W  = 4;
  localparam int CNT_W = 2;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Counters run down to zero, so a span of n cycles preloads n-1.
  function automatic logic [GAP_W-1:0] span_preload(input int n);
    if (n > 0) begin
      span_preload = GAP_W'(n - 1);
    end else begin
      span_preload = {GAP_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/shift4_ctrl_cnt.sv
// Loadable down-counter with clear, enable and a zero flag.
// Shared by the bit count and the gap count of shift4_ctrl.
module shift4_ctrl_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over load, load wins over decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/shift4_ctrl.sv
// Load/shift sequencer for an external 4-bit right-shift register.
// Define SHIFT4_CTRL_PAUSE_EN to add the ser_stall input.
module shift4_ctrl
  import shift4_ctrl_pkg::*;
#(
  parameter int SHIFTS = 4,
  parameter int GAP    = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SR_W-1:0] in_data,
  output logic            sr_load,
  output logic            sr_ena,
  output logic [SR_W-1:0] sr_data,
  input  logic [SR_W-1:0] sr_q,
  output logic            ser_valid,
  output logic            ser_bit,
  output logic            word_done,
  output logic            busy
`ifdef SHIFT4_CTRL_PAUSE_EN
  ,
  input  logic            ser_stall
`endif
);

  localparam logic [CNT_W-1:0] BIT_PRELOAD = CNT_W'(SHIFTS - 1);
  localparam logic [GAP_W-1:0] GAP_PRELOAD = span_preload(GAP);
  localparam logic             HAS_GAP     = (GAP > 0);

  state_e          state_q;
  state_e          state_d;
  logic [SR_W-1:0] hold_q;
  logic [SR_W-1:0] hold_d;

  logic stall_s;
  logic bit_clr_s;
  logic bit_load_s;
  logic bit_en_s;
  logic bit_zero_s;
  logic gap_load_s;
  logic gap_en_s;
  logic gap_zero_s;
  logic sr_q_unused;

`ifdef SHIFT4_CTRL_PAUSE_EN
  assign stall_s = (state_q == ST_SHIFT) && ser_stall;
`else
  assign stall_s = 1'b0;
`endif

  // Only q[0] is observed; the upper bits belong to the register.
  assign sr_q_unused = ^sr_q[SR_W-1:1];

  assign bit_clr_s = (state_q == ST_IDLE);

  shift4_ctrl_cnt #(.W(CNT_W)) u_bit_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (bit_clr_s),
    .load     (bit_load_s),
    .load_val (BIT_PRELOAD),
    .en       (bit_en_s),
    .zero     (bit_zero_s)
  );

  shift4_ctrl_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (bit_clr_s),
    .load     (gap_load_s),
    .load_val (GAP_PRELOAD),
    .en       (gap_en_s),
    .zero     (gap_zero_s)
  );

  // Next-state, hold capture and counter control.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    bit_load_s = 1'b0;
    bit_en_s   = 1'b0;
    gap_load_s = 1'b0;
    gap_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bit_load_s = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (stall_s) begin
          state_d = ST_SHIFT;
        end else if (!bit_zero_s) begin
          bit_en_s = 1'b1;
          state_d  = ST_SHIFT;
        end else if (HAS_GAP) begin
          gap_load_s = 1'b1;
          state_d    = ST_GAP;
        end else if (in_valid) begin
          // Back-to-back words: accept the next nibble on the last bit.
          hold_d  = in_data;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          gap_en_s = 1'b1;
          state_d  = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and hold registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      hold_q  <= {SR_W{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Moore output decode; a stall freezes the current bit and masks completion.
  always_comb begin
    in_ready  = 1'b0;
    sr_load   = 1'b0;
    sr_ena    = 1'b0;
    ser_valid = 1'b0;
    word_done = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_LOAD: begin
        sr_load = 1'b1;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        sr_ena    = !stall_s;
        word_done = bit_zero_s && !stall_s;
        in_ready  = bit_zero_s && !stall_s && !HAS_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sr_data = hold_q;
  assign ser_bit = sr_q[0];

endmodule
